// File: rtl/gcltypes.sv
// Shared gcla_m command types, plus the arbiter state and idle NOP encoding.
package gcltypes;

  localparam int unsigned A_size = 8;
  localparam int unsigned D_SIZE = 16;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    WRA  = 2'd1,
    RDA  = 2'd2,
    CPAB = 2'd3
  } gclcmd_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    gclcmd_t           cmd;
    logic [A_size-1:0] adr1;
    logic [A_size-1:0] adr2;
    logic [D_SIZE-1:0] data;
  } gclop_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Value driven to gcla_m whenever no requester command is accepted.
  localparam gclop_t GCL_NOP_OP = '{id: 4'hf, cmd: NOP, adr1: '0, adr2: '0, data: '0};

endpackage

// File: rtl/gcl_cmd_arb_if.sv
// Requester-side command handshake bundle for gcl_cmd_arb.
interface gcl_cmd_arb_if
  import gcltypes::*;
#(
  parameter int unsigned N_REQ = 2
);
  logic   [N_REQ-1:0] req_valid;
  gclop_t [N_REQ-1:0] req_op;
  logic   [N_REQ-1:0] req_lock;
  logic   [N_REQ-1:0] req_ready;

  modport master (output req_valid, output req_op, output req_lock, input req_ready);
  modport slave  (input req_valid, input req_op, input req_lock, output req_ready);
endinterface

// File: rtl/gcl_rr_pick.sv
// Rotate-priority picker: first valid bit searching upward from rr_ptr+1 (mod N).
module gcl_rr_pick #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] rr_ptr,
  output logic [N-1:0]   grant_c,
  output logic [IDW-1:0] idx_c
);

  logic           found;
  logic [IDW-1:0] pos;

  // Walk the ring once, starting just after the last winner.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = IDW'((32'(rr_ptr) + k) % N);
      if (!found && valid[pos]) begin
        found        = 1'b1;
        grant_c[pos] = 1'b1;
        idx_c        = pos;
      end
    end
  end

endmodule

// File: rtl/gcl_cmd_arb.sv
// Round-robin command arbiter with per-requester lock in front of gcla_m.
// Optional per-requester/stall statistics under GCL_ARB_STATS_EN.
module gcl_cmd_arb
  import gcltypes::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned IDW      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  gcl_cmd_arb_if.slave         req_if,
  input  logic                 dp_stall,
  output gclop_t               gclop_out,
  output logic [IDW-1:0]       grant_id,
  output logic                 out_valid,
  output logic                 lock_abort
`ifdef GCL_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0] stat_grants,
  output logic [15:0]            stat_stall
`endif
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [CW-1:0]  idle_cnt_q, idle_cnt_d;
  gclop_t         gclop_out_q, gclop_out_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           out_valid_q, out_valid_d;
  logic           lock_abort_q, lock_abort_d;

  logic [N_REQ-1:0] pick_grant_c;
  logic [IDW-1:0]   pick_idx_c;
  logic [N_REQ-1:0] ready_c;
  logic [IDW-1:0]   gnt_idx_c;

  gcl_rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
    .valid   (req_if.req_valid),
    .rr_ptr  (rr_ptr_q),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c)
  );

  assign req_if.req_ready = ready_c;
  assign gclop_out        = gclop_out_q;
  assign grant_id         = grant_id_q;
  assign out_valid        = out_valid_q;
  assign lock_abort       = lock_abort_q;

  // Grant selection, lock tracking and next registered output.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    idle_cnt_d   = idle_cnt_q;
    gclop_out_d  = gclop_out_q;
    grant_id_d   = grant_id_q;
    out_valid_d  = out_valid_q;
    lock_abort_d = 1'b0;
    ready_c      = '0;
    gnt_idx_c    = pick_idx_c;

    if (!dp_stall && !reset) begin
      unique case (state_q)
        IDLE: ready_c = pick_grant_c;
        LOCKED: begin
          gnt_idx_c = owner_q;
          if (req_if.req_valid[owner_q]) begin
            ready_c[owner_q] = 1'b1;
          end else if (idle_cnt_q == CW'(LOCK_MAX - 1)) begin
            // Owner went quiet too long: drop the lock, nobody granted now.
            state_d      = IDLE;
            lock_abort_d = 1'b1;
            idle_cnt_d   = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      if (|ready_c) begin
        gclop_out_d = req_if.req_op[gnt_idx_c];
        grant_id_d  = gnt_idx_c;
        out_valid_d = 1'b1;
        idle_cnt_d  = '0;
        if (state_q == IDLE) begin
          rr_ptr_d = gnt_idx_c;
          if (req_if.req_lock[gnt_idx_c]) begin
            state_d = LOCKED;
            owner_d = gnt_idx_c;
          end
        end else if (!req_if.req_lock[gnt_idx_c]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
        end
      end else begin
        gclop_out_d = GCL_NOP_OP;
        out_valid_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= IDW'(N_REQ - 1);
      owner_q      <= '0;
      idle_cnt_q   <= '0;
      gclop_out_q  <= GCL_NOP_OP;
      grant_id_q   <= '0;
      out_valid_q  <= 1'b0;
      lock_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      idle_cnt_q   <= idle_cnt_d;
      gclop_out_q  <= gclop_out_d;
      grant_id_q   <= grant_id_d;
      out_valid_q  <= out_valid_d;
      lock_abort_q <= lock_abort_d;
    end
  end

`ifdef GCL_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] stat_grants_q, stat_grants_d;
  logic [15:0]            stat_stall_q, stat_stall_d;

  assign stat_grants = stat_grants_q;
  assign stat_stall  = stat_stall_q;

  // Saturating transfer and stall counters.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stall_d  = stat_stall_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ready_c[i] && stat_grants_q[i] != 16'hFFFF) begin
        stat_grants_d[i] = stat_grants_q[i] + 16'd1;
      end
    end
    if (dp_stall && stat_stall_q != 16'hFFFF) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stall_q  <= stat_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_gcl_cmd_arb.sv
// Directed bench for gcl_cmd_arb: reset, round-robin, lock burst with stall,
// lock timeout and reset while locked.
module tb_gcl_cmd_arb;
  import gcltypes::*;

  localparam int unsigned N_REQ    = 2;
  localparam int unsigned LOCK_MAX = 16;

  logic   clk = 1'b0;
  logic   reset;
  logic   dp_stall;
  gclop_t gclop_out;
  logic   [0:0] grant_id;
  logic   out_valid;
  logic   lock_abort;
`ifdef GCL_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] stat_grants;
  logic [15:0]            stat_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;

  gcl_cmd_arb_if #(.N_REQ(N_REQ)) rif ();

  gcl_cmd_arb #(.N_REQ(N_REQ), .LOCK_MAX(LOCK_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_if     (rif.slave),
    .dp_stall   (dp_stall),
    .gclop_out  (gclop_out),
    .grant_id   (grant_id),
    .out_valid  (out_valid),
    .lock_abort (lock_abort)
`ifdef GCL_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic gclop_t mk(input logic [3:0] id, input gclcmd_t c,
                                input logic [7:0] a1, input logic [7:0] a2,
                                input logic [15:0] d);
    gclop_t o;
    o.id   = id;
    o.cmd  = c;
    o.adr1 = a1;
    o.adr2 = a2;
    o.data = d;
    return o;
  endfunction

  function automatic gclop_t cpab(input int j);
    return mk(4'h1, CPAB, 8'(6 + j), 8'(2 + j), 16'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  gclop_t op0, op1, opc;

  initial begin
    op0 = mk(4'h0, WRA, 8'h0, 8'h0, 16'h2);
    op1 = mk(4'h1, RDA, 8'h2, 8'h0, 16'h0);

    // Reset with both requesters asserting valid.
    reset         = 1'b1;
    dp_stall      = 1'b0;
    rif.req_valid = 2'b11;
    rif.req_lock  = 2'b00;
    rif.req_op[0] = op0;
    rif.req_op[1] = op1;
    tick();
    tick();
    chk("rst_op", 64'(gclop_out), 64'(GCL_NOP_OP));
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_abort", 64'(lock_abort), 64'd0);
    chk("rst_ready", 64'(rif.req_ready), 64'd0);
    reset = 1'b0;

    // Round-robin: rr_ptr starts at 1, so req0 wins first.
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rr_ready", 64'(rif.req_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
      tick();
      chk("rr_op", 64'(gclop_out), (k % 2 == 1) ? 64'(op1) : 64'(op0));
      chk("rr_gid", 64'(grant_id), 64'(k % 2));
      chk("rr_oval", 64'(out_valid), 64'd1);
    end
`ifdef GCL_ARB_STATS_EN
    chk("stat_g0", 64'(stat_grants[0]), 64'd5);
    chk("stat_g1", 64'(stat_grants[1]), 64'd5);
`endif

    // req0 takes its turn, then req1 starts a locked CPAB burst.
    rif.req_op[1]   = cpab(0);
    rif.req_lock[1] = 1'b1;
    #1;
    chk("pre_ready", 64'(rif.req_ready), 64'd1);
    tick();
    chk("pre_op", 64'(gclop_out), 64'(op0));

    for (int j = 0; j < 6; j++) begin
      if (j == 3) begin
        // Three stall cycles mid-burst; cpab(3) waits, output holds cpab(2).
        rif.req_op[1] = cpab(3);
        dp_stall      = 1'b1;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk("st_ready", 64'(rif.req_ready), 64'd0);
          tick();
          chk("st_op", 64'(gclop_out), 64'(cpab(2)));
          chk("st_oval", 64'(out_valid), 64'd1);
          chk("st_abort", 64'(lock_abort), 64'd0);
        end
        dp_stall = 1'b0;
      end
      rif.req_op[1]   = cpab(j);
      rif.req_lock[1] = (j < 5);
      #1;
      chk("lb_ready", 64'(rif.req_ready), 64'd2);
      tick();
      chk("lb_op", 64'(gclop_out), 64'(cpab(j)));
      chk("lb_gid", 64'(grant_id), 64'd1);
      chk("lb_abort", 64'(lock_abort), 64'd0);
    end

    // Lock released with rr_ptr = 1: req0 is next.
    rif.req_valid[1] = 1'b0;
    rif.req_lock[1]  = 1'b0;
    #1;
    chk("rel_ready", 64'(rif.req_ready), 64'd1);
    tick();
    chk("rel_op", 64'(gclop_out), 64'(op0));
    chk("rel_gid", 64'(grant_id), 64'd0);
`ifdef GCL_ARB_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'd3);
`endif

    // Lock timeout: req1 locks, then goes silent for LOCK_MAX cycles.
    opc              = mk(4'h1, CPAB, 8'hC, 8'h8, 16'h0);
    rif.req_valid[1] = 1'b1;
    rif.req_op[1]    = opc;
    rif.req_lock[1]  = 1'b1;
    #1;
    chk("to_lock_ready", 64'(rif.req_ready), 64'd2);
    tick();
    chk("to_lock_op", 64'(gclop_out), 64'(opc));
    rif.req_valid[1] = 1'b0;
    rif.req_lock[1]  = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk("to_ready", 64'(rif.req_ready), 64'd0);
      chk("to_abort0", 64'(lock_abort), 64'd0);
      tick();
    end
    chk("to_abort1", 64'(lock_abort), 64'd1);
    chk("to_ready_after", 64'(rif.req_ready), 64'd1);
    tick();
    chk("to_op", 64'(gclop_out), 64'(op0));
    chk("to_gid", 64'(grant_id), 64'd0);
    chk("to_abort_end", 64'(lock_abort), 64'd0);

    // Reset while LOCKED: back to IDLE, no abort pulse.
    opc              = mk(4'h1, CPAB, 8'hD, 8'h9, 16'h0);
    rif.req_valid[1] = 1'b1;
    rif.req_op[1]    = opc;
    rif.req_lock[1]  = 1'b1;
    #1;
    chk("rl_lock_ready", 64'(rif.req_ready), 64'd2);
    tick();
    chk("rl_lock_op", 64'(gclop_out), 64'(opc));
    rif.req_valid[1] = 1'b0;
    rif.req_lock[1]  = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rl_rst_ready", 64'(rif.req_ready), 64'd0);
    tick();
    chk("rl_abort", 64'(lock_abort), 64'd0);
    chk("rl_op", 64'(gclop_out), 64'(GCL_NOP_OP));
    chk("rl_oval", 64'(out_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("rl_idle_ready", 64'(rif.req_ready), 64'd1);
    tick();
    chk("rl_abort2", 64'(lock_abort), 64'd0);
    chk("rl_op2", 64'(gclop_out), 64'(op0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gcl_cmd_arb.md
Name: gcl_cmd_arb

Overview:
- Shares the single gclop_t command input of the gcla_m datapath between N_REQ requesters, for example the compacting collector controller and a mutator write/read port.
- Arbitration is round-robin with a per-requester lock, so a multi-word CPAB object copy can run as an uninterrupted burst.
- Output is registered and drives gcla_m directly.
- Emits NOP when no command is accepted.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- LOCK_MAX, 16, consecutive idle cycles of a lock owner before the lock is forcibly released.
- IDW, $clog2(N_REQ), width of the grant index.

Ports:
- clk  input  1  clock.
- reset  input  1  reset. One clock; reset is synchronous and active-high.
- req_valid  input  N_REQ  per-requester command valid.
- req_op  input  N_REQ x gclop_t  per-requester command.
- req_lock  input  N_REQ  hold the grant after this command is accepted.
- req_ready  output  N_REQ  command accepted this cycle (combinational).
- dp_stall  input  1  datapath cannot take a new command this cycle.
- gclop_out  output  gclop_t  registered command to gcla_m.
- grant_id  output  IDW  index of the requester whose op is on gclop_out.
- out_valid  output  1  gclop_out carries a requester command, not an arbiter NOP.
- lock_abort  output  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset values (synchronous, reset wins over all other inputs):
  - gclop_out = {id:'hf, cmd:NOP, all other fields '0}.
  - out_valid = 0, grant_id = 0, lock_abort = 0.
  - FSM = IDLE, rr_ptr = N_REQ-1, idle counter = 0.
- Handshake:
  - Transfer occurs when req_valid[i] && req_ready[i].
  - A requester must hold req_valid and req_op stable until it is accepted.
  - At most one req_ready bit is high per cycle, and none while dp_stall = 1.
- Latency: an op accepted in cycle t appears on gclop_out in cycle t+1, with out_valid = 1 and grant_id = i. The op fields pass through unmodified, including id.
- dp_stall = 1: gclop_out, out_valid and grant_id hold their values; no transfer; FSM state and rr_ptr hold.
- No transfer and dp_stall = 0: gclop_out becomes the reset NOP and out_valid = 0.
- State IDLE:
  - Grant goes to the first valid requester searching from rr_ptr+1 modulo N_REQ.
  - On transfer, rr_ptr <= i.
  - If req_lock[i] = 1 on the transfer, go to LOCKED with owner = i.
- State LOCKED:
  - Only the owner can be granted; the other requesters see ready = 0.
  - A transfer with req_lock = 0 releases: go to IDLE and set rr_ptr <= owner.
  - A transfer with req_lock = 1 stays in LOCKED.
  - The idle counter increments on each non-stall cycle with req_valid[owner] = 0, and clears on each owner transfer.
  - When the counter reaches LOCK_MAX: go to IDLE, pulse lock_abort for one cycle, clear the counter.
  - No grant is given in the abort cycle.
- Stall cycles do not count toward LOCK_MAX.
- Reset while LOCKED returns to IDLE with no lock_abort pulse.
- rr_ptr wraps modulo N_REQ.
- A single valid requester is granted every non-stall cycle (back-to-back, full throughput).

Optional Feature:
- Macro: GCL_ARB_STATS_EN.
- Defined: adds output stat_grants (N_REQ x 16 bits), a saturating count of transfers per requester, and output stat_stall (16 bits), a saturating count of dp_stall cycles. Both clear on reset; counters stick at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package gcltypes holds:
  - gclop_t, the cmd enum (NOP, WRA, RDA, CPAB) and A_size.
  - New: the arb_state_t enum {IDLE, LOCKED} and the GCL_NOP_OP constant (the reset NOP value).
- One sub-module, gcl_rr_pick: purely combinational rotate-priority picker.
  - Inputs: valid vector, rr_ptr.
  - Outputs: one-hot grant and index.
  - Reused by later schedulers.

Test Plan:
- Reset: assert reset for 2 cycles with both req_valid = 1 -> gclop_out = NOP id 'hf, out_valid = 0, req_ready = 0.
- Round-robin:
  - Stimulus: both requesters continuously valid; req0 = WRA adr1 'h0 data 'h2; req1 = RDA adr1 'h2.
  - Required: gclop_out alternates req0, req1, req0 ... one cycle after each accept; grant_id alternates 0, 1.
- Lock burst:
  - Stimulus: req1 issues CPAB adr1 'h6..'hB to adr2 'h2..'h7 with lock = 1 on the first 5 ops and lock = 0 on the last; req0 valid throughout.
  - Required: six consecutive req1 ops on gclop_out, then req0 granted.
- Stall:
  - Stimulus: dp_stall = 1 for 3 cycles mid-burst.
  - Required: gclop_out holds the same CPAB for 3 cycles, req_ready = 0, the burst resumes unchanged and lock_abort stays 0.
- Lock timeout:
  - Stimulus: with LOCK_MAX = 16, the owner holds the lock then drops valid for 16 cycles.
  - Required: lock_abort pulses once in cycle 16; the next cycle grants another valid requester.
- Reset mid-lock, and stats:
  - Stimulus: reset asserted in LOCKED.
  - Required: IDLE with no abort pulse.
  - With GCL_ARB_STATS_EN defined: after the round-robin test of 10 transfers, stat_grants = {5, 5}.
